// File: rtl/io_chk_pkg.sv
// io_chk_pkg: shared FSM state type, error codes and clog2 helper for the protocol checker
package io_chk_pkg;
  typedef enum logic [2:0] {S_IDLE, S_IN, S_WAIT, S_OUT, S_ERR} state_t;
  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_OVERLAP  = 3'd1;
  localparam logic [2:0] E_OUTNZ    = 3'd2;
  localparam logic [2:0] E_INLEN    = 3'd3;
  localparam logic [2:0] E_TIMEOUT  = 3'd4;
  localparam logic [2:0] E_DATA     = 3'd5;
  localparam logic [2:0] E_OUTLEN   = 3'd6;
  localparam logic [2:0] E_UNDER    = 3'd7;
  localparam logic [2:0] E_SPURIOUS = 3'd7;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/io_chk_fifo.sv
// io_chk_fifo: golden-word FIFO with first-word-fall-through read; i_push/i_wdata in, i_pop/o_rdata out, o_full/o_empty flags
module io_chk_fifo
  import io_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int AW = DEPTH > 1 ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_rdata = r_mem[r_rp];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge clk)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_wdata;
endmodule

// File: rtl/io_protocol_checker.sv
// io_protocol_checker: monitors in_valid/out_valid/out handshakes against burst, latency and golden-data rules; reports pass, counts and sticky err_code
module io_protocol_checker
  import io_chk_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IN_LEN    = 96,
  parameter int OUT_LEN   = 1,
  parameter int MAX_LAT   = 100,
  parameter int EXP_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        out_valid,
  input  logic [DATA_W-1:0]           out,
  input  logic                        exp_push,
  input  logic [DATA_W-1:0]           exp_data,
  output logic                        exp_full,
  output logic                        busy,
  output logic                        pass,
  output logic [CNT_W-1:0]            pat_cnt,
  output logic [clog2(MAX_LAT+1)-1:0] last_lat,
  output logic [CNT_W-1:0]            total_lat,
  output logic                        err,
  output logic [2:0]                  err_code
);
  localparam int LW = clog2(MAX_LAT + 1);
  localparam int IW = clog2(IN_LEN + 1);
  localparam int OW = clog2(OUT_LEN + 1);
  state_t r_state, w_state;
  logic [IW-1:0] r_in_cnt, w_in_cnt;
  logic [LW-1:0] r_lat, w_lat, r_last_lat;
  logic [OW-1:0] r_out_cnt, w_out_cnt;
  logic [CNT_W-1:0] r_pat_cnt, r_total_lat;
  logic [CNT_W:0] w_sum;
  logic r_pass, r_err;
  logic [2:0] r_err_code, w_code;
  logic w_empty, w_pop, w_first, w_done, w_ok;
  logic w_ovl, w_nz, w_inlen, w_tmo, w_data, w_outlen, w_under;
  logic [DATA_W-1:0] w_rd;
  io_chk_fifo #(.DATA_W(DATA_W), .DEPTH(EXP_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(exp_push), .i_wdata(exp_data), .i_pop(w_pop),
    .o_full(exp_full), .o_empty(w_empty), .o_rdata(w_rd)
  );
  assign busy      = r_state inside {S_IN, S_WAIT, S_OUT};
  assign pass      = r_pass;
  assign pat_cnt   = r_pat_cnt;
  assign last_lat  = r_last_lat;
  assign total_lat = r_total_lat;
  assign err       = r_err;
  assign err_code  = r_err_code;
  // r_lat holds the latency of the current cycle: the drop cycle in IN counts as 1, so WAIT starts at 2
  always_comb begin
    w_state   = r_state;
    w_in_cnt  = r_in_cnt;
    w_lat     = r_lat;
    w_out_cnt = r_out_cnt;
    w_pop     = 1'b0;
    w_first   = 1'b0;
    w_done    = 1'b0;
    w_inlen   = 1'b0;
    w_tmo     = 1'b0;
    w_outlen  = 1'b0;
    w_under   = 1'b0;
    w_ovl     = in_valid & out_valid;
    w_nz      = ~out_valid && out != '0;
    case (r_state)
      S_IDLE: begin
        w_under = out_valid;
        if (in_valid) begin
          w_state  = S_IN;
          w_in_cnt = IW'(1);
        end
      end
      S_IN:
        if (in_valid) begin
          w_inlen  = r_in_cnt == IW'(IN_LEN);
          w_in_cnt = r_in_cnt + IW'(1);
        end else if (r_in_cnt != IW'(IN_LEN)) w_inlen = 1'b1;
        else if (out_valid) begin
          w_first = 1'b1;
          w_lat   = LW'(1);
        end else if (MAX_LAT == 1) w_tmo = 1'b1;
        else begin
          w_state = S_WAIT;
          w_lat   = LW'(2);
        end
      S_WAIT:
        if (out_valid) w_first = 1'b1;
        else if (r_lat == LW'(MAX_LAT)) w_tmo = 1'b1;
        else w_lat = r_lat + LW'(1);
      S_OUT:
        if (out_valid) begin
          w_outlen  = r_out_cnt == OW'(OUT_LEN);
          w_pop     = ~w_outlen;
          w_out_cnt = r_out_cnt + OW'(1);
        end else if (r_out_cnt != OW'(OUT_LEN)) w_outlen = 1'b1;
        else begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      default: ;
    endcase
    if (w_first) begin
      w_state   = S_OUT;
      w_pop     = 1'b1;
      w_out_cnt = OW'(1);
    end
    w_under = w_under | (w_pop & w_empty);
    w_data  = w_pop & ~w_empty & (w_rd != out);
    w_code  = w_ovl    ? E_OVERLAP :
              w_nz     ? E_OUTNZ   :
              w_inlen  ? E_INLEN   :
              w_tmo    ? E_TIMEOUT :
              w_data   ? E_DATA    :
              w_outlen ? E_OUTLEN  :
              w_under  ? E_UNDER   : E_NONE;
    w_ok    = w_code == E_NONE;
    if (!w_ok) w_state = S_ERR;
    w_sum   = {1'b0, r_total_lat} + (CNT_W + 1)'(w_lat);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_lat       <= '0;
      r_out_cnt   <= '0;
      r_pass      <= 1'b0;
      r_pat_cnt   <= '0;
      r_last_lat  <= '0;
      r_total_lat <= '0;
      r_err       <= 1'b0;
      r_err_code  <= E_NONE;
    end else begin
      r_state   <= w_state;
      r_in_cnt  <= w_in_cnt;
      r_lat     <= w_lat;
      r_out_cnt <= w_out_cnt;
      r_pass    <= w_done & w_ok;
      if (w_done && w_ok) r_pat_cnt <= r_pat_cnt + CNT_W'(r_pat_cnt != '1);
      if (w_first && w_ok) begin
        r_last_lat  <= w_lat;
        r_total_lat <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end
      if (!r_err && !w_ok) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
endmodule

// File: tb/tb_io_protocol_checker.sv
// tb_io_protocol_checker: table, hand-sequence and randomized model checks of io_protocol_checker
module tb_io_protocol_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  localparam logic [31:0] G = 32'h3F80_0000;
  logic rst_a = 1'b1, iv_a = 1'b0, ov_a = 1'b0, push_a = 1'b0;
  logic [31:0] out_a = '0, ed_a = '0;
  logic full_a, busy_a, pass_a, err_a;
  logic [15:0] pc_a, tl_a;
  logic [6:0] ll_a;
  logic [2:0] ec_a;
  io_protocol_checker dut_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .out_valid(ov_a), .out(out_a),
    .exp_push(push_a), .exp_data(ed_a), .exp_full(full_a), .busy(busy_a), .pass(pass_a),
    .pat_cnt(pc_a), .last_lat(ll_a), .total_lat(tl_a), .err(err_a), .err_code(ec_a)
  );
  logic rst_b = 1'b1, iv_b = 1'b0, ov_b = 1'b0, push_b = 1'b0;
  logic [31:0] out_b = '0, ed_b = '0;
  logic full_b, busy_b, pass_b, err_b;
  logic [15:0] pc_b, tl_b;
  logic [2:0] ll_b;
  logic [2:0] ec_b;
  io_protocol_checker #(.DATA_W(32), .IN_LEN(3), .OUT_LEN(4), .MAX_LAT(6), .EXP_DEPTH(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .out_valid(ov_b), .out(out_b),
    .exp_push(push_b), .exp_data(ed_b), .exp_full(full_b), .busy(busy_b), .pass(pass_b),
    .pat_cnt(pc_b), .last_lat(ll_b), .total_lat(tl_b), .err(err_b), .err_code(ec_b)
  );
  logic [31:0] bw[8];
  logic [31:0] bp[4];
  logic bpe = 1'b0;
  typedef struct {
    string name;
    int len, lat, olen;
    logic [31:0] gold, dout;
    int code, pc;
  } vec_t;
  vec_t tv[7];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic rst_A;
    rst_a = 1; iv_a = 0; ov_a = 0; out_a = 0; push_a = 0; ed_a = 0;
    step;
    rst_a = 0;
  endtask
  task automatic push_A(input logic [31:0] w);
    push_a = 1; ed_a = w;
    step;
    push_a = 0; ed_a = 0;
  endtask
  task automatic pat_A(input int len, input int lat, input int olen, input logic [31:0] w);
    iv_a = 1;
    repeat (len) step;
    iv_a = 0;
    repeat (lat - 1) step;
    ov_a = 1; out_a = w;
    repeat (olen) step;
    ov_a = 0; out_a = 0;
    step;
  endtask
  task automatic rst_B;
    rst_b = 1; iv_b = 0; ov_b = 0; out_b = 0; push_b = 0; ed_b = 0;
    step;
    rst_b = 0;
  endtask
  task automatic push_B(input logic [31:0] w);
    push_b = 1; ed_b = w;
    step;
    push_b = 0; ed_b = 0;
  endtask
  task automatic pat_B(input int len, input int lat, input int olen);
    iv_b = 1;
    repeat (len) step;
    iv_b = 0;
    repeat (lat - 1) step;
    for (int i = 0; i < olen; i++) begin
      ov_b = 1; out_b = bw[i]; push_b = bpe && i < 4; ed_b = bp[i % 4];
      step;
    end
    ov_b = 0; out_b = 0; push_b = 0; ed_b = 0;
    step;
  endtask
  initial begin
    int len, lat, olen, code, np, m_pc, m_tl;
    logic [31:0] w;
    logic [31:0] q[$];
    tv[0] = '{"good_l1",   96, 1,   1, G,     G,     0, 1};
    tv[1] = '{"good_l100", 96, 100, 1, G,     G,     0, 1};
    tv[2] = '{"short_in",  95, 5,   1, G,     G,     3, 0};
    tv[3] = '{"long_in",   97, 5,   1, G,     G,     3, 0};
    tv[4] = '{"timeout",   96, 101, 1, G,     G,     4, 0};
    tv[5] = '{"data",      96, 3,   1, 32'h1, 32'h2, 5, 0};
    tv[6] = '{"long_out",  96, 3,   2, G,     G,     6, 0};
    rst_A;
    rst_B;
    chk("rst_busy", busy_a, 0); chk("rst_pass", pass_a, 0); chk("rst_pc", pc_a, 0);
    chk("rst_ll", ll_a, 0); chk("rst_tl", tl_a, 0); chk("rst_err", err_a, 0);
    chk("rst_ec", ec_a, 0); chk("rst_full", full_a, 0);
    push_A(G);
    pat_A(96, 5, 1, G);
    chk("t1_pass", pass_a, 1); chk("t1_pc", pc_a, 1); chk("t1_ll", ll_a, 5);
    chk("t1_tl", tl_a, 5); chk("t1_err", err_a, 0);
    step;
    chk("t1_pass_pulse", pass_a, 0); chk("t1_busy_idle", busy_a, 0);
    for (int i = 0; i < 7; i++) begin
      rst_A;
      push_A(tv[i].gold);
      pat_A(tv[i].len, tv[i].lat, tv[i].olen, tv[i].dout);
      chk({tv[i].name, "_code"}, ec_a, tv[i].code);
      chk({tv[i].name, "_err"}, err_a, tv[i].code != 0);
      chk({tv[i].name, "_pc"}, pc_a, tv[i].pc);
    end
    rst_A;
    push_A(G);
    iv_a = 1;
    repeat (49) step;
    chk("ovl_busy_before", busy_a, 1);
    ov_a = 1; out_a = G;
    step;
    chk("ovl_code", ec_a, 1); chk("ovl_err", err_a, 1); chk("ovl_busy", busy_a, 0);
    iv_a = 0; ov_a = 0; out_a = 32'h5;
    repeat (3) step;
    chk("ovl_sticky", ec_a, 1); chk("ovl_nopass", pass_a, 0);
    rst_A;
    out_a = 32'h5;
    step;
    chk("outnz_code", ec_a, 2);
    rst_A;
    ov_a = 1;
    step;
    chk("spurious_code", ec_a, 7);
    rst_A;
    iv_a = 1; ov_a = 1;
    step;
    chk("prio_code", ec_a, 1);
    rst_A;
    push_A(G);
    pat_A(96, 5, 1, G);
    push_A(G);
    iv_a = 1;
    repeat (96) step;
    iv_a = 0;
    repeat (99) step;
    chk("tmo_not_yet", ec_a, 0); chk("tmo_busy", busy_a, 1);
    step;
    chk("tmo_code", ec_a, 4); chk("tmo_ll_kept", ll_a, 5);
    rst_A;
    push_A(32'h11); push_A(32'h22); push_A(32'h33);
    pat_A(96, 1, 1, 32'h11);
    chk("b2b_pass1", pass_a, 1);
    pat_A(96, 7, 1, 32'h22);
    chk("b2b_pass2", pass_a, 1);
    pat_A(96, 100, 1, 32'h33);
    chk("b2b_pass3", pass_a, 1); chk("b2b_pc", pc_a, 3);
    chk("b2b_tl", tl_a, 108); chk("b2b_ll", ll_a, 100); chk("b2b_err", err_a, 0);
    push_A(G);
    iv_a = 1;
    repeat (40) step;
    rst_A;
    chk("mid_busy", busy_a, 0); chk("mid_pass", pass_a, 0); chk("mid_pc", pc_a, 0);
    chk("mid_ll", ll_a, 0); chk("mid_tl", tl_a, 0); chk("mid_err", err_a, 0);
    chk("mid_ec", ec_a, 0); chk("mid_full", full_a, 0);
    pat_A(96, 2, 1, G);
    chk("mid_flushed", ec_a, 7);
    rst_B;
    for (int i = 0; i < 4; i++) begin
      bw[i] = 32'hA0 + i;
      push_B(bw[i]);
    end
    chk("fifo_full", full_b, 1);
    push_B(32'hDEAD);
    chk("fifo_full_drop", full_b, 1);
    pat_B(3, 2, 4);
    chk("fifo_pass", pass_b, 1); chk("fifo_pc", pc_b, 1); chk("fifo_empty", full_b, 0);
    pat_B(3, 2, 4);
    chk("fifo_under", ec_b, 7);
    rst_B;
    for (int i = 0; i < 4; i++) begin
      bw[i] = 32'hB0 + i;
      bp[i] = 32'hC0 + i;
      push_B(bw[i]);
    end
    bpe = 1;
    pat_B(3, 1, 4);
    bpe = 0;
    chk("pp_pass1", pass_b, 1); chk("pp_full", full_b, 1); chk("pp_err1", err_b, 0);
    for (int i = 0; i < 4; i++) bw[i] = bp[i];
    pat_B(3, 6, 4);
    chk("pp_pass2", pass_b, 1); chk("pp_pc", pc_b, 2); chk("pp_ll", ll_b, 6);
    chk("pp_tl", tl_b, 7); chk("pp_drained", full_b, 0);
    rst_B;
    q.delete();
    m_pc = 0;
    m_tl = 0;
    for (int it = 0; it < 80; it++) begin
      np = $urandom_range(0, 5);
      for (int k = 0; k < np; k++) begin
        w = $urandom;
        push_B(w);
        if (q.size() < 4) q.push_back(w);
      end
      chk("rnd_full", full_b, q.size() == 4);
      len  = $urandom_range(0, 9) == 0 ? 2 : $urandom_range(0, 9) == 0 ? 4 : 3;
      lat  = $urandom_range(0, 9) == 0 ? 7 : $urandom_range(1, 6);
      olen = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 9) == 0 ? 5 : 4;
      for (int i = 0; i < 8; i++) begin
        bw[i] = i < q.size() ? q[i] : $urandom;
        if ($urandom_range(0, 15) == 0) bw[i] = bw[i] ^ 32'h100;
      end
      code = 0;
      if (len != 3) code = 3;
      else if (lat > 6) code = 4;
      else begin
        for (int i = 0; i < (olen < 4 ? olen : 4) && code == 0; i++)
          if (q.size() == 0) code = 7;
          else if (q.pop_front() != bw[i]) code = 5;
        if (code == 0 && olen != 4) code = 6;
      end
      pat_B(len, lat, olen);
      chk("rnd_code", ec_b, code);
      if (code == 0) begin
        m_pc++;
        m_tl += lat;
        chk("rnd_pass", pass_b, 1);
        chk("rnd_ll", ll_b, lat);
        chk("rnd_tl", tl_b, m_tl);
        chk("rnd_pc", pc_b, m_pc);
      end else begin
        chk("rnd_err", err_b, 1);
        chk("rnd_nopass", pass_b, 0);
        rst_B;
        q.delete();
        m_pc = 0;
        m_tl = 0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/io_protocol_checker.md
# io_protocol_checker

Synthesizable, parametrised transaction monitor that sits beside a lab DUT on the emulation/FPGA bench and checks every DUT handshake against the course I/O rules. It enforces fixed-length `in_valid` bursts, an idle gap, a bounded output latency and a fixed-length `out_valid` burst. It compares each `out` word against a golden stream preloaded into an internal FIFO, and reports per-pattern latency, pass count and a sticky error code.

## Interface
- `DATA_W`, 32: width of `out` and golden words.
- `IN_LEN`, 96: required `in_valid` burst length in cycles (≥1).
- `OUT_LEN`, 1: required `out_valid` burst length in cycles (≥1).
- `MAX_LAT`, 100: maximum cycles from burst end to first `out_valid` (≥1).
- `EXP_DEPTH`, 8: golden FIFO depth, power of two, ≥`OUT_LEN`.
- `CNT_W`, 16: width of `pat_cnt` and `total_lat`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: DUT input-valid as driven by the stimulus.
- `out_valid` in 1: DUT output-valid.
- `out` in `DATA_W`: DUT output data.
- `exp_push` in 1: write `exp_data` into the golden FIFO.
- `exp_data` in `DATA_W`: golden word.
- `exp_full` out 1: golden FIFO full.
- `busy` out 1: FSM not in IDLE or ERR.
- `pass` out 1: one-cycle pulse when a pattern completes cleanly.
- `pat_cnt` out `CNT_W`: patterns passed (saturating).
- `last_lat` out `clog2(MAX_LAT+1)`: latency of the most recent pattern.
- `total_lat` out `CNT_W`: accumulated latency (saturating).
- `err` out 1: sticky error flag.
- `err_code` out 3: first error seen (sticky).

## Operation
- States: IDLE, IN, WAIT, OUT, ERR. Reset forces IDLE, empties the FIFO and clears every output and counter to 0.
- IDLE: `in_valid`=1 → IN, `in_cnt`=1. Seeing `out_valid`=1 here raises `E_SPURIOUS`.
- IN: counts consecutive `in_valid` cycles.
  - `in_valid` dropping while `in_cnt`<`IN_LEN` raises `E_INLEN`.
  - `in_valid` still high after `in_cnt`=`IN_LEN` raises `E_INLEN`.
  - Drop exactly at `IN_LEN` → WAIT, `lat`=1.
- WAIT: `out_valid`=1 → OUT, records `last_lat`=`lat`, adds `lat` to `total_lat`, compares the first word. Otherwise `lat`+1. If `lat`=`MAX_LAT` and `out_valid`=0, raise `E_TIMEOUT`.
- OUT: each `out_valid` cycle pops one FIFO word and compares it with `out`.
  - Any inequality raises `E_DATA`.
  - Popping an empty FIFO raises `E_UNDER`.
  - `out_valid` dropping before `OUT_LEN` words raises `E_OUTLEN`.
  - `out_valid` still high after `OUT_LEN` words raises `E_OUTLEN`.
  - Exactly `OUT_LEN` words followed by `out_valid`=0 → `pass` pulse, `pat_cnt`+1, then IDLE.
- Every state checks:
  - `in_valid`&`out_valid` raises `E_OVERLAP`.
  - `out_valid`=0 with `out`≠0 raises `E_OUTNZ`.
- Error codes: 0 none, 1 `E_OVERLAP`, 2 `E_OUTNZ`, 3 `E_INLEN`, 4 `E_TIMEOUT`, 5 `E_DATA`, 6 `E_OUTLEN`, 7 `E_UNDER`/`E_SPURIOUS`.
- Error priority within one cycle: lowest code wins.
- Any error → ERR. ERR is absorbing until `rst`; `err_code` holds the first error only.
- Golden FIFO: push is ignored when full, with no error raised. Push and pop in the same cycle is legal at any fill level; a simultaneous push and pop when full is accepted. FIFO pointers wrap modulo `EXP_DEPTH`.
- Counters saturate at all-ones; they never wrap.

## Timing
- All outputs are registered; every result appears one cycle after the sampling edge.
- `pass` is asserted in the cycle after the first `out_valid`=0 that follows a complete burst.
- Latency semantics: first `out_valid` in the cycle right after the last `in_valid` cycle → `last_lat`=1.
- A new burst may start the cycle after `pass`; the IDLE state consumes that cycle as the burst's first `in_valid`.
- `rst` mid-pattern discards all progress, including FIFO contents, on the next edge.

## Structure
- Package `io_chk_pkg`: state enum, the 3-bit error-code constants, and a clog2 helper function.
- Sub-module `io_chk_fifo`: the golden FIFO (parametrised `DATA_W`, `EXP_DEPTH`), exposing full/empty flags and a first-word-fall-through read.
- The top level holds the FSM, counters and compare logic.

## Test plan
- Preload 1 word `0x3F800000`; drive a 96-cycle burst; return `out_valid` with `out`=`0x3F800000` after 5 idle cycles → `pass` asserts, `pat_cnt`=1, `last_lat`=5, `err`=0.
- Overlap: assert `out_valid` during burst cycle 50 → `err_code`=1 one cycle later, state ERR, no `pass`.
- Timeout: complete the burst, never assert `out_valid` → `err_code`=4 at `lat`=100; `last_lat` unchanged.
- Length: drive a 95-cycle burst → `err_code`=3. Separately, golden `0x1` with DUT `0x2` → `err_code`=5. Separately, `out`=`0x5` while `out_valid`=0 → `err_code`=2.
- FIFO boundary with `OUT_LEN`=4, `EXP_DEPTH`=4:
  - Fill to `exp_full`=1; a fifth push is dropped.
  - Pushes during OUT keep the stream correct.
  - A pattern with an empty FIFO → `err_code`=7.
- Back-to-back 3 patterns with latencies 1, 7, 100 → `pat_cnt`=3, `total_lat`=108; `rst` mid-burst returns every output to 0.
